// File: rtl/lpddr2_responder.sv
// lpddr2_responder: memory-side responder for the CPU's LPDDR2 window.
//
// Turns CPU load/store requests into single-word Avalon-MM commands for the
// LPDDR2 controller. A one-entry posted write buffer absorbs stores, and a
// one-word read tag register (rd_tag/rd_data) lets a held read_req hit without
// re-reading DRAM. A read that waits too long for its data is aborted: err is
// set and ERR_WORD is returned.
//
// Optional feature (macro LPDDR2_FWD_EN): a read whose address matches the
// pending write buffer is served from the buffer one cycle later, with no DRAM
// access. Without the macro such a read stalls until the write has drained,
// then reads DRAM normally.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   address, write_data       CPU word address and store data
//   write_req, read_req       store strobe, level read request
//   read_data, busy, err      read result, CPU stall, sticky timeout flag
//   avl_ready                 controller calibration/init done
//   avl_addr/wdata/be         Avalon command address, write data, byte enable
//   avl_read/write            Avalon commands (registered)
//   avl_waitrequest           command not accepted this cycle
//   avl_rdata/rdata_valid     Avalon read return
module lpddr2_responder #(
  parameter int unsigned AVL_ADDR_W = 27,
  parameter int unsigned TIMEOUT    = 1023,
  parameter logic [31:0] ERR_WORD   = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [26:0]           address,
  input  logic [31:0]           write_data,
  input  logic                  write_req,
  input  logic                  read_req,
  output logic [31:0]           read_data,
  output logic                  busy,
  output logic                  err,
  input  logic                  avl_ready,
  output logic [AVL_ADDR_W-1:0] avl_addr,
  output logic [31:0]           avl_wdata,
  output logic [3:0]            avl_be,
  output logic                  avl_read,
  output logic                  avl_write,
  input  logic                  avl_waitrequest,
  input  logic [31:0]           avl_rdata,
  input  logic                  avl_rdata_valid
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StWrCmd, StRdCmd, StRdWait} state_e;

  state_e                state_q, state_d;
  logic                  wbuf_full_q, wbuf_full_d;
  logic [26:0]           wbuf_addr_q, wbuf_addr_d;
  logic [31:0]           wbuf_data_q, wbuf_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [26:0]           rd_tag_q, rd_tag_d;
  logic [31:0]           read_data_q, read_data_d;
  logic [26:0]           miss_addr_q, miss_addr_d;
  logic                  err_q, err_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  avl_read_q, avl_read_d;
  logic                  avl_write_q, avl_write_d;
  logic [AVL_ADDR_W-1:0] avl_addr_q, avl_addr_d;
  logic [31:0]           avl_wdata_q, avl_wdata_d;

  logic tag_match, pend_match, hit, fwd, rd_miss, wr_capture;
  // Set once rd_data already holds the pending buffer's data, so the tag may hit.
  logic wbuf_fwd_q;

  assign tag_match  = rd_valid_q && (rd_tag_q == address);
  assign pend_match = wbuf_full_q && (wbuf_addr_q == address);
  // A tag hit on an address with a pending write is stale unless it was forwarded.
  assign hit        = read_req && tag_match && (!pend_match || wbuf_fwd_q);
  assign wr_capture = write_req && !wbuf_full_q;

`ifdef LPDDR2_FWD_EN
  logic wbuf_fwd_d;

  // Only forward when no DRAM read is in flight, so a fill can never overwrite it.
  assign fwd = read_req && pend_match && !hit && ((state_q == StIdle) || (state_q == StWrCmd));

  always_comb begin
    wbuf_fwd_d = wbuf_fwd_q;
    if (wr_capture) begin
      wbuf_fwd_d = 1'b0;
    end else if (fwd) begin
      wbuf_fwd_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbuf_fwd_q <= 1'b0;
    end else begin
      wbuf_fwd_q <= wbuf_fwd_d;
    end
  end
`else
  assign fwd        = 1'b0;
  assign wbuf_fwd_q = 1'b0;
`endif

  assign rd_miss = read_req && !hit && !fwd;
  assign busy    = !avl_ready || (write_req && wbuf_full_q) || (read_req && !hit);

  always_comb begin
    state_d     = state_q;
    wbuf_full_d = wbuf_full_q;
    wbuf_addr_d = wbuf_addr_q;
    wbuf_data_d = wbuf_data_q;
    rd_valid_d  = rd_valid_q;
    rd_tag_d    = rd_tag_q;
    read_data_d = read_data_q;
    miss_addr_d = miss_addr_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    avl_read_d  = avl_read_q;
    avl_write_d = avl_write_q;
    avl_addr_d  = avl_addr_q;
    avl_wdata_d = avl_wdata_q;

    if (wr_capture) begin
      wbuf_full_d = 1'b1;
      wbuf_addr_d = address;
      wbuf_data_d = write_data;
    end

    if (fwd) begin
      read_data_d = wbuf_data_q;
      rd_tag_d    = address;
      rd_valid_d  = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (avl_ready) begin
          if (wbuf_full_q) begin
            state_d     = StWrCmd;
            avl_write_d = 1'b1;
            avl_addr_d  = AVL_ADDR_W'(wbuf_addr_q);
            avl_wdata_d = wbuf_data_q;
          end else if (rd_miss) begin
            state_d     = StRdCmd;
            avl_read_d  = 1'b1;
            avl_addr_d  = AVL_ADDR_W'(address);
            miss_addr_d = address;
          end
        end
      end
      StWrCmd: begin
        if (!avl_waitrequest) begin
          avl_write_d = 1'b0;
          wbuf_full_d = 1'b0;
          // Write-through keeps the cached word coherent with DRAM.
          if (rd_valid_q && (rd_tag_q == wbuf_addr_q)) begin
            read_data_d = wbuf_data_q;
          end
          state_d = StIdle;
        end
      end
      StRdCmd: begin
        if (!avl_waitrequest) begin
          avl_read_d = 1'b0;
          cnt_d      = '0;
          state_d    = StRdWait;
        end
      end
      StRdWait: begin
        if (avl_rdata_valid) begin
          read_data_d = avl_rdata;
          rd_tag_d    = miss_addr_q;
          rd_valid_d  = 1'b1;
          state_d     = StIdle;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          // Abort after TIMEOUT cycles in RD_WAIT; a late return lands in IDLE and is dropped.
          err_d       = 1'b1;
          read_data_d = ERR_WORD;
          rd_valid_d  = 1'b0;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wbuf_full_q <= 1'b0;
      wbuf_addr_q <= '0;
      wbuf_data_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_tag_q    <= '0;
      read_data_q <= '0;
      miss_addr_q <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      avl_read_q  <= 1'b0;
      avl_write_q <= 1'b0;
      avl_addr_q  <= '0;
      avl_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wbuf_full_q <= wbuf_full_d;
      wbuf_addr_q <= wbuf_addr_d;
      wbuf_data_q <= wbuf_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_tag_q    <= rd_tag_d;
      read_data_q <= read_data_d;
      miss_addr_q <= miss_addr_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      avl_read_q  <= avl_read_d;
      avl_write_q <= avl_write_d;
      avl_addr_q  <= avl_addr_d;
      avl_wdata_q <= avl_wdata_d;
    end
  end

  assign read_data = read_data_q;
  assign err       = err_q;
  assign avl_read  = avl_read_q;
  assign avl_write = avl_write_q;
  assign avl_addr  = avl_addr_q;
  assign avl_wdata = avl_wdata_q;
  assign avl_be    = 4'hF;

endmodule

// File: tb/tb_lpddr2_responder.sv
// Bench for lpddr2_responder: directed scenarios plus randomized CPU traffic.
// A behavioural Avalon controller with sparse DRAM answers commands; a CPU-level
// reference memory predicts every read result and the ordered list of writes.
module tb_lpddr2_responder;

  localparam int TMO = 1023;

  logic        clk, rst;
  logic [26:0] address;
  logic [31:0] write_data;
  logic        write_req, read_req;
  logic [31:0] read_data;
  logic        busy, err, avl_ready;
  logic [26:0] avl_addr;
  logic [31:0] avl_wdata;
  logic [3:0]  avl_be;
  logic        avl_read, avl_write, avl_waitrequest;
  logic [31:0] avl_rdata;
  logic        avl_rdata_valid;

  lpddr2_responder #(
    .AVL_ADDR_W(27),
    .TIMEOUT   (TMO),
    .ERR_WORD  (32'hDEADBEEF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .address        (address),
    .write_data     (write_data),
    .write_req      (write_req),
    .read_req       (read_req),
    .read_data      (read_data),
    .busy           (busy),
    .err            (err),
    .avl_ready      (avl_ready),
    .avl_addr       (avl_addr),
    .avl_wdata      (avl_wdata),
    .avl_be         (avl_be),
    .avl_read       (avl_read),
    .avl_write      (avl_write),
    .avl_waitrequest(avl_waitrequest),
    .avl_rdata      (avl_rdata),
    .avl_rdata_valid(avl_rdata_valid)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Controller-side state.
  logic [31:0] dram [logic [26:0]];
  logic [63:0] obs_wr [$];
  int          n_rd = 0, n_wr = 0;
  int          last_rd_cyc = 0, last_wr_cyc = 0;
  logic [26:0] last_rd_addr = '0;
  bit          rand_mode = 0, drop_reads = 0;
  int          stall_cfg = 0, lat_cfg = 2;

  // CPU-level reference.
  logic [31:0] ref_mem [logic [26:0]];
  logic [63:0] exp_wr [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [26:0] a);
    return {5'd0, a} ^ 32'h9E3779B9;
  endfunction

  function automatic logic [31:0] dram_rd(input logic [26:0] a);
    return dram.exists(a) ? dram[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [26:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Avalon controller model: waitrequest and return data are driven on the falling edge.
  initial begin
    bit          cmd_seen = 0;
    bit          rd_pend = 0;
    int          stall_left = 0;
    int          rd_delay = 0;
    logic [26:0] rd_addr = '0;
    avl_waitrequest = 1'b1;
    avl_rdata_valid = 1'b0;
    avl_rdata       = '0;
    forever begin
      @(negedge clk);
      avl_rdata_valid = 1'b0;
      avl_waitrequest = 1'b1;
      if (rst) begin
        cmd_seen = 0;
        rd_pend  = 0;
      end else begin
        if (rd_pend) begin
          if (rd_delay == 0) begin
            avl_rdata_valid = 1'b1;
            avl_rdata       = dram_rd(rd_addr);
            rd_pend         = 0;
          end else begin
            rd_delay--;
          end
        end
        if (avl_read || avl_write) begin
          if (!cmd_seen) begin
            cmd_seen   = 1;
            stall_left = rand_mode ? int'($urandom_range(0, 3)) : stall_cfg;
          end
          if (stall_left > 0) begin
            stall_left--;
          end else begin
            // Accepted at the coming rising edge.
            avl_waitrequest = 1'b0;
            cmd_seen        = 0;
            if (avl_write) begin
              dram[avl_addr] = avl_wdata;
              obs_wr.push_back({5'd0, avl_addr, avl_wdata});
              n_wr++;
              last_wr_cyc = cyc;
            end else begin
              n_rd++;
              last_rd_cyc  = cyc;
              last_rd_addr = avl_addr;
              rd_addr      = avl_addr;
              rd_delay     = rand_mode ? int'($urandom_range(0, 6)) : lat_cfg;
              rd_pend      = !drop_reads;
            end
          end
        end
      end
    end
  end

  // Called just after a falling edge with a request driven; returns stall cycles seen.
  task automatic wait_not_busy(input string tag, output int bcyc);
    bcyc = 0;
    #1;
    while (busy && bcyc < 2000) begin
      @(negedge clk);
      #1;
      bcyc++;
    end
    check({tag, " stall bound"}, 64'(busy), 64'd0);
  endtask

  task automatic cpu_write(input logic [26:0] a, input logic [31:0] d, output int bcyc);
    @(negedge clk);
    address    = a;
    write_data = d;
    write_req  = 1'b1;
    wait_not_busy("wr", bcyc);
    @(posedge clk);
    #1;
    write_req = 1'b0;
    ref_mem[a] = d;
    exp_wr.push_back({5'd0, a, d});
  endtask

  task automatic cpu_read(input logic [26:0] a, output int bcyc);
    @(negedge clk);
    address  = a;
    read_req = 1'b1;
    wait_not_busy("rd", bcyc);
    check("rd data", 64'(read_data), 64'(ref_rd(a)));
    @(posedge clk);
    #1;
    read_req = 1'b0;
  endtask

  initial begin
    int          b, b2, viol, nrd0, nwr0, k, dcyc, r;
    logic [26:0] a;
    logic [31:0] d;

    rst        = 1'b1;
    avl_ready  = 1'b0;
    read_req   = 1'b0;
    write_req  = 1'b0;
    address    = '0;
    write_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset read_data", 64'(read_data), 64'd0);
    check("reset err", 64'(err), 64'd0);
    check("reset avl_read", 64'(avl_read), 64'd0);
    check("reset avl_write", 64'(avl_write), 64'd0);
    check("reset avl_addr", 64'(avl_addr), 64'd0);
    check("reset avl_wdata", 64'(avl_wdata), 64'd0);
    check("avl_be", 64'(avl_be), 64'hF);
    check("reset busy while not ready", 64'(busy), 64'd1);

    // Init gating.
    @(negedge clk);
    address  = 27'h10;
    read_req = 1'b1;
    viol     = 0;
    repeat (20) begin
      #1;
      if (busy !== 1'b1 || avl_read !== 1'b0) viol++;
      @(negedge clk);
    end
    check("init gating", 64'(viol), 64'd0);
    avl_ready = 1'b1;
    @(negedge clk);
    #1;
    check("init avl_read", 64'(avl_read), 64'd1);
    check("init avl_addr", 64'(avl_addr), 64'h10);
    wait_not_busy("init", b);
    check("init data", 64'(read_data), 64'(ref_rd(27'h10)));
    @(posedge clk);
    #1;
    read_req = 1'b0;

    // Read miss then hit.
    stall_cfg = 2;
    lat_cfg   = 5;
    dram[27'h100]    = 32'hCAFEF00D;
    ref_mem[27'h100] = 32'hCAFEF00D;
    nrd0 = n_rd;
    cpu_read(27'h100, b);
    check("miss stalled", 64'(b > 0), 64'd1);
    check("miss one read", 64'(n_rd), 64'(nrd0 + 1));
    @(negedge clk);
    address  = 27'h100;
    read_req = 1'b1;
    viol     = 0;
    repeat (10) begin
      #1;
      if (busy !== 1'b0) viol++;
      @(negedge clk);
    end
    read_req = 1'b0;
    check("hit no stall", 64'(viol), 64'd0);
    check("hit no read", 64'(n_rd), 64'(nrd0 + 1));

    // Write-through.
    nwr0 = n_wr;
    nrd0 = n_rd;
    cpu_write(27'h100, 32'h12345678, b);
    repeat (10) @(negedge clk);
    #1;
    check("wt one write", 64'(n_wr), 64'(nwr0 + 1));
    check("wt read_data", 64'(read_data), 64'h12345678);
    cpu_read(27'h100, b);
    check("wt hit no stall", 64'(b), 64'd0);
    check("wt no read", 64'(n_rd), 64'(nrd0));

    // Back-to-back writes.
    stall_cfg = 4;
    cpu_write(27'h5, 32'h0000_0555, b);
    cpu_write(27'h6, 32'h0000_0666, b2);
    check("b2b second stalled", 64'(b2 > 0), 64'd1);
    repeat (20) @(negedge clk);
    check("b2b first", obs_wr[obs_wr.size() - 2], {5'd0, 27'h5, 32'h0000_0555});
    check("b2b second", obs_wr[obs_wr.size() - 1], {5'd0, 27'h6, 32'h0000_0666});

    // Read of an address with a pending write.
    stall_cfg = 6;
    lat_cfg   = 3;
    nrd0 = n_rd;
    cpu_write(27'h7, 32'hAA55AA55, b);
    cpu_read(27'h7, b);
`ifdef LPDDR2_FWD_EN
    check("fwd one busy cycle", 64'(b), 64'd1);
    check("fwd no read", 64'(n_rd), 64'(nrd0));
    repeat (20) @(negedge clk);
    check("fwd no read after drain", 64'(n_rd), 64'(nrd0));
`else
    check("nofwd one read", 64'(n_rd), 64'(nrd0 + 1));
    check("nofwd write before read", 64'(last_wr_cyc < last_rd_cyc), 64'd1);
    check("nofwd read addr", 64'(last_rd_addr), 64'h7);
`endif

    // Timeout.
    stall_cfg  = 0;
    lat_cfg    = 2;
    drop_reads = 1;
    nrd0 = n_rd;
    @(negedge clk);
    address  = 27'h9;
    read_req = 1'b1;
    k = 0;
    #1;
    while (!err && k < TMO + 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("tmo err", 64'(err), 64'd1);
    check("tmo word", 64'(read_data), 64'hDEADBEEF);
    dcyc = cyc - last_rd_cyc;
    check("tmo delay", 64'(dcyc >= TMO && dcyc <= TMO + 2), 64'd1);
    drop_reads = 0;
    wait_not_busy("tmo retry", b);
    check("retry data", 64'(read_data), 64'(ref_rd(27'h9)));
    check("retry read count", 64'(n_rd), 64'(nrd0 + 2));
    check("err sticky", 64'(err), 64'd1);
    @(posedge clk);
    #1;
    read_req = 1'b0;

    // Reset clears err and the cached word.
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst err", 64'(err), 64'd0);
    check("rst read_data", 64'(read_data), 64'd0);
    rst = 1'b0;
    nrd0 = n_rd;
    cpu_read(27'h9, b);
    check("post-reset miss", 64'(n_rd), 64'(nrd0 + 1));

    // Randomized traffic over a small address set.
    rand_mode = 1;
    for (int i = 0; i < 300; i++) begin
      a = 27'(32'h40 + $urandom_range(0, 7));
      r = int'($urandom_range(0, 99));
      if (r < 40) begin
        d = $urandom;
        cpu_write(a, d, b);
      end else begin
        cpu_read(a, b);
        if (r > 80) begin
          nrd0 = n_rd;
          cpu_read(a, b);
          check("reread no stall", 64'(b), 64'd0);
          check("reread no dram", 64'(n_rd), 64'(nrd0));
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    check("write count", 64'(obs_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
      check("write log", obs_wr[i], exp_wr[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
